// File: rtl/udma_i2c_pkg.sv
// Opcode map, payload-length decode and arbiter state encoding for the I2C command arbiter.
// ST_ABORT_STOP is present only when UDMA_I2C_ARB_TIMEOUT_EN is defined.
package udma_i2c_pkg;

  localparam logic [3:0] CMD_START   = 4'h0;
  localparam logic [3:0] CMD_WAIT_EV = 4'h1;
  localparam logic [3:0] CMD_STOP    = 4'h2;
  localparam logic [3:0] CMD_RD_ACK  = 4'h4;
  localparam logic [3:0] CMD_RD_NACK = 4'h6;
  localparam logic [3:0] CMD_WR      = 4'h8;
  localparam logic [3:0] CMD_WAIT    = 4'hA;
  localparam logic [3:0] CMD_RPT     = 4'hC;
  localparam logic [3:0] CMD_CFG     = 4'hE;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_PAYLOAD
`ifdef UDMA_I2C_ARB_TIMEOUT_EN
    ,
    ST_ABORT_STOP
`endif
  } arb_state_e;

  // Number of operand bytes that follow an opcode; anything unlisted carries none.
  function automatic logic [1:0] payload_len(input logic [3:0] opcode);
    logic [1:0] len;
    case (opcode)
      CMD_WR, CMD_RPT, CMD_WAIT: len = 2'd1;
      CMD_CFG:                   len = 2'd2;
      default:                   len = 2'd0;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/udma_i2c_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping modulo NB_REQ.
module udma_i2c_rr_pick #(
  parameter int NB_REQ = 2,
  parameter int PTR_W  = $clog2(NB_REQ)
) (
  input  logic [NB_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]  ptr_i,
  output logic              valid_o,
  output logic [PTR_W-1:0]  idx_o,
  output logic [NB_REQ-1:0] gnt_o
);

  logic [NB_REQ-1:0][PTR_W-1:0] cand_idx;

  for (genvar gi = 0; gi < NB_REQ; gi++) begin : g_cand
    assign cand_idx[gi] = PTR_W'((int'(ptr_i) + gi) % NB_REQ);
  end

  // Scan from the farthest candidate back so the one nearest the pointer wins.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    for (int i = NB_REQ - 1; i >= 0; i--) begin
      if (req_i[cand_idx[i]]) begin
        valid_o = 1'b1;
        idx_o   = cand_idx[i];
      end
    end
    gnt_o = '0;
    if (valid_o) gnt_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/udma_i2c_cmd_arb.sv
// Round-robin arbiter sharing the 8-bit I2C command stream between NB_REQ sources, locked per STOP-terminated sequence.
// Optional stall timeout with injected STOP: define UDMA_I2C_ARB_TIMEOUT_EN.
module udma_i2c_cmd_arb
  import udma_i2c_pkg::*;
#(
  parameter int NB_REQ    = 2,
  parameter int TIMEOUT_W = 16
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   sw_rst_i,
  input  logic [NB_REQ-1:0][7:0] req_data_i,
  input  logic [NB_REQ-1:0]      req_valid_i,
  output logic [NB_REQ-1:0]      req_ready_o,
  output logic [7:0]             out_data_o,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [NB_REQ-1:0]      grant_o,
  output logic                   busy_o,
  output logic                   err_o
);

  localparam int PTR_W = $clog2(NB_REQ);

  arb_state_e          state_q, state_d;
  logic [NB_REQ-1:0]   grant_q, grant_d;
  logic [PTR_W-1:0]    gidx_q, gidx_d;
  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [1:0]          payload_cnt_q, payload_cnt_d;

  logic                pick_valid;
  logic [PTR_W-1:0]    pick_idx;
  logic [NB_REQ-1:0]   pick_gnt;
  logic [7:0]          own_data;
  logic                own_valid;
  logic                xfer;
  logic [PTR_W-1:0]    ptr_after_owner;

  udma_i2c_rr_pick #(
    .NB_REQ (NB_REQ),
    .PTR_W  (PTR_W)
  ) u_rr_pick (
    .req_i   (req_valid_i),
    .ptr_i   (rr_ptr_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx),
    .gnt_o   (pick_gnt)
  );

  // One-hot mux from the owner; with no owner everything reads as zero.
  always_comb begin
    own_data  = '0;
    own_valid = 1'b0;
    for (int i = 0; i < NB_REQ; i++) begin
      if (grant_q[i]) begin
        own_data  = req_data_i[i];
        own_valid = req_valid_i[i];
      end
    end
  end

  assign ptr_after_owner = (gidx_q == PTR_W'(NB_REQ - 1)) ? '0 : gidx_q + 1'b1;

  always_comb begin
    out_data_o  = own_data;
    out_valid_o = own_valid;
    req_ready_o = grant_q & {NB_REQ{out_ready_i}};
`ifdef UDMA_I2C_ARB_TIMEOUT_EN
    if (state_q == ST_ABORT_STOP) begin
      out_data_o  = {CMD_STOP, 4'h0};
      out_valid_o = 1'b1;
      req_ready_o = '0;
    end
`endif
  end

  assign xfer    = out_valid_o & out_ready_i;
  assign grant_o = grant_q;
  assign busy_o  = (state_q != ST_IDLE);

`ifdef UDMA_I2C_ARB_TIMEOUT_EN
  localparam logic [TIMEOUT_W-1:0] TMO_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
  logic [TIMEOUT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic                 err_q, err_d;
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    gidx_d        = gidx_q;
    rr_ptr_d      = rr_ptr_q;
    payload_cnt_d = payload_cnt_q;
`ifdef UDMA_I2C_ARB_TIMEOUT_EN
    tmo_cnt_d     = tmo_cnt_q;
    err_d         = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          grant_d = pick_gnt;
          gidx_d  = pick_idx;
          state_d = ST_CMD;
`ifdef UDMA_I2C_ARB_TIMEOUT_EN
          tmo_cnt_d = '0;
`endif
        end
      end
      ST_CMD: begin
        if (xfer) begin
          if (out_data_o[7:4] == CMD_STOP) begin
            state_d  = ST_IDLE;
            grant_d  = '0;
            rr_ptr_d = ptr_after_owner;
          end else if (payload_len(out_data_o[7:4]) != 2'd0) begin
            payload_cnt_d = payload_len(out_data_o[7:4]);
            state_d       = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        // Operand bytes are only counted, never decoded, so 0x2X here cannot end the sequence.
        if (xfer) begin
          payload_cnt_d = payload_cnt_q - 2'd1;
          if (payload_cnt_q == 2'd1) state_d = ST_CMD;
        end
      end
`ifdef UDMA_I2C_ARB_TIMEOUT_EN
      ST_ABORT_STOP: begin
        if (xfer) begin
          state_d       = ST_IDLE;
          grant_d       = '0;
          rr_ptr_d      = ptr_after_owner;
          payload_cnt_d = '0;
          tmo_cnt_d     = '0;
          err_d         = 1'b1;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase

`ifdef UDMA_I2C_ARB_TIMEOUT_EN
    if (state_q == ST_CMD || state_q == ST_PAYLOAD) begin
      if (xfer) begin
        tmo_cnt_d = '0;
      end else if (!own_valid) begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
        if (tmo_cnt_q == TMO_LAST) begin
          state_d       = ST_ABORT_STOP;
          payload_cnt_d = '0;
        end
      end
    end
`endif

    // The controller is reset by the same abort, so no STOP is owed to it.
    if (sw_rst_i) begin
      state_d       = ST_IDLE;
      grant_d       = '0;
      gidx_d        = '0;
      rr_ptr_d      = '0;
      payload_cnt_d = '0;
`ifdef UDMA_I2C_ARB_TIMEOUT_EN
      tmo_cnt_d     = '0;
      err_d         = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q       <= ST_IDLE;
      grant_q       <= '0;
      gidx_q        <= '0;
      rr_ptr_q      <= '0;
      payload_cnt_q <= '0;
`ifdef UDMA_I2C_ARB_TIMEOUT_EN
      tmo_cnt_q     <= '0;
      err_q         <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      gidx_q        <= gidx_d;
      rr_ptr_q      <= rr_ptr_d;
      payload_cnt_q <= payload_cnt_d;
`ifdef UDMA_I2C_ARB_TIMEOUT_EN
      tmo_cnt_q     <= tmo_cnt_d;
      err_q         <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_udma_i2c_cmd_arb.sv
// Self-checking bench for udma_i2c_cmd_arb: byte scoreboard, table of single-source sequences, hand-written arbitration cases.
module tb_udma_i2c_cmd_arb;

  localparam int NB_REQ = 2;

  logic                   clk_i = 1'b0;
  logic                   rstn_i;
  logic                   sw_rst_i;
  logic [NB_REQ-1:0][7:0] req_data_i;
  logic [NB_REQ-1:0]      req_valid_i;
  logic [NB_REQ-1:0]      req_ready_o;
  logic [7:0]             out_data_o;
  logic                   out_valid_o;
  logic                   out_ready_i;
  logic [NB_REQ-1:0]      grant_o;
  logic                   busy_o;
  logic                   err_o;

  always #5 clk_i = ~clk_i;

  udma_i2c_cmd_arb #(
    .NB_REQ    (NB_REQ),
    .TIMEOUT_W (4)
  ) dut (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .sw_rst_i    (sw_rst_i),
    .req_data_i  (req_data_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .out_data_o  (out_data_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .grant_o     (grant_o),
    .busy_o      (busy_o),
    .err_o       (err_o)
  );

  typedef struct packed {
    logic [1:0] gnt;
    logic [7:0] data;
  } exp_t;

  typedef struct {
    int unsigned r;
    int unsigned n;
    logic [47:0] bytes;
  } vec_t;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] src0_q[$];
  logic [7:0] src1_q[$];
  exp_t       exp_q[$];
  logic       abort_win = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic drive();
    req_valid_i[0] = (src0_q.size() != 0);
    req_data_i[0]  = (src0_q.size() != 0) ? src0_q[0] : 8'h00;
    req_valid_i[1] = (src1_q.size() != 0);
    req_data_i[1]  = (src1_q.size() != 0) ? src1_q[0] : 8'h00;
  endtask

  task automatic load(input int r, input logic [7:0] b);
    if (r == 0) src0_q.push_back(b);
    else        src1_q.push_back(b);
  endtask

  task automatic sb_push(input int r, input logic [7:0] b);
    exp_t e;
    e.gnt  = (r == 0) ? 2'b01 : 2'b10;
    e.data = b;
    exp_q.push_back(e);
  endtask

  task automatic send(input int r, input logic [7:0] b);
    load(r, b);
    sb_push(r, b);
  endtask

  // One clock: sample on the falling edge, then retire accepted source bytes after the rising edge.
  task automatic step();
    logic f0, f1;
    exp_t e;
    @(negedge clk_i);
    check("ready_mirror", req_ready_o, abort_win ? 2'b00 : (grant_o & {NB_REQ{out_ready_i}}));
    if (out_valid_o && out_ready_i) begin
      $display("xfer grant=%b data=%02h t=%0t", grant_o, out_data_o, $time);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_xfer: got data %02h grant %b, required no transfer", out_data_o, grant_o);
      end else begin
        e = exp_q.pop_front();
        check("xfer_data", out_data_o, e.data);
        check("xfer_grant", grant_o, e.gnt);
      end
    end
    f0 = req_valid_i[0] & req_ready_o[0];
    f1 = req_valid_i[1] & req_ready_o[1];
    @(posedge clk_i);
    #1;
    if (f0) void'(src0_q.pop_front());
    if (f1) void'(src1_q.pop_front());
    drive();
  endtask

  task automatic run_until_idle(input string name, input int budget);
    int  n;
    bit  done;
    n    = 0;
    done = 1'b0;
    while (!done && n < budget) begin
      step();
      n++;
      done = (exp_q.size() == 0) && (src0_q.size() == 0) && (src1_q.size() == 0) && !busy_o;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s: not idle after %0d cycles, %0d bytes still expected", name, budget, exp_q.size());
    end
  endtask

  // seq holds n two-bit grant values, first cycle in the most significant pair.
  task automatic grant_trace(input string name, input int n, input logic [31:0] seq);
    for (int k = 1; k <= n; k++) begin
      step();
      check(name, grant_o, seq[2*(n-k) +: 2]);
    end
  endtask

  task automatic do_reset();
    rstn_i      = 1'b0;
    sw_rst_i    = 1'b0;
    out_ready_i = 1'b1;
    src0_q.delete();
    src1_q.delete();
    exp_q.delete();
    req_valid_i = 2'b11;
    req_data_i  = {8'hAA, 8'h55};
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_out_valid", out_valid_o, 1'b0);
    check("rst_out_data", out_data_o, 8'h00);
    check("rst_req_ready", req_ready_o, 2'b00);
    check("rst_grant", grant_o, 2'b00);
    check("rst_busy", busy_o, 1'b0);
    check("rst_err", err_o, 1'b0);
    drive();
    @(posedge clk_i);
    #1;
    rstn_i = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t        vecs [7];
  logic [47:0] bv;
  logic [1:0]  gexp;
  int          r;
  int          n;
  logic [9:0]  rdy_pat;

  initial begin
    // r, bytes until the sequence ends, bytes (first byte in the top octet)
    vecs[0] = '{0, 4, 48'h00_80_20_20_00_00};
    vecs[1] = '{1, 4, 48'hE0_20_20_20_00_00};
    vecs[2] = '{0, 5, 48'hA0_20_C0_20_20_00};
    vecs[3] = '{1, 3, 48'h30_50_20_00_00_00};
    vecs[4] = '{0, 1, 48'h20_00_00_00_00_00};
    vecs[5] = '{1, 4, 48'h40_60_10_20_00_00};
    vecs[6] = '{0, 3, 48'h80_2F_2F_00_00_00};

    do_reset();

    for (int v = 0; v < 7; v++) begin
      r    = int'(vecs[v].r);
      n    = int'(vecs[v].n);
      bv   = vecs[v].bytes;
      gexp = (r == 0) ? 2'b01 : 2'b10;
      for (int i = 0; i < n; i++) send(r, bv[47-8*i -: 8]);
      drive();
      for (int k = 1; k <= n + 1; k++) begin
        step();
        check("vec_busy", busy_o, (k <= n) ? 1'b1 : 1'b0);
        check("vec_grant", grant_o, (k <= n) ? gexp : 2'b00);
      end
      check("vec_drained", exp_q.size(), 0);
    end

    // Both sources valid from reset: 0, then 1, then 0 again, one bubble between sequences.
    do_reset();
    send(0, 8'h00); send(0, 8'h20);
    send(1, 8'h00); send(1, 8'h20);
    send(0, 8'h80); send(0, 8'h55); send(0, 8'h20);
    exp_q.delete();
    sb_push(0, 8'h00); sb_push(0, 8'h20);
    sb_push(1, 8'h00); sb_push(1, 8'h20);
    sb_push(0, 8'h80); sb_push(0, 8'h55); sb_push(0, 8'h20);
    drive();
    grant_trace("rr_grant", 10, 32'b01_01_00_10_10_00_01_01_01_00);
    run_until_idle("rr_idle", 10);

    // CFG payload equal to STOP keeps source 1 locked while source 0 waits.
    send(1, 8'hE0); send(1, 8'h20); send(1, 8'h20); send(1, 8'h20);
    send(0, 8'h00); send(0, 8'h20);
    drive();
    grant_trace("cfg_lock_grant", 8, 32'b10_10_10_10_00_01_01_00);
    run_until_idle("cfg_idle", 10);

    // Controller back-pressure in the middle of a sequence.
    send(0, 8'h00); send(0, 8'h80); send(0, 8'h20); send(0, 8'h20);
    drive();
    rdy_pat = 10'b1101010011;
    for (int k = 9; k >= 0; k--) begin
      out_ready_i = rdy_pat[k];
      step();
    end
    out_ready_i = 1'b1;
    run_until_idle("toggle_idle", 20);

    // Software abort inside PAYLOAD; rr_ptr was 1, so source 0 winning proves it returned to 0.
    send(0, 8'h00); send(0, 8'hE0);
    load(0, 8'h11); load(0, 8'h22); load(0, 8'h20);
    drive();
    repeat (3) step();
    out_ready_i = 1'b0;
    sw_rst_i    = 1'b1;
    step();
    sw_rst_i    = 1'b0;
    out_ready_i = 1'b1;
    src0_q.delete();
    drive();
    check("swrst_grant", grant_o, 2'b00);
    check("swrst_busy", busy_o, 1'b0);
    check("swrst_drained", exp_q.size(), 0);
    send(0, 8'h00); send(0, 8'h20);
    send(1, 8'h00); send(1, 8'h20);
    drive();
    grant_trace("swrst_grant_trace", 6, 32'b01_01_00_10_10_00);
    run_until_idle("swrst_idle", 10);

`ifdef UDMA_I2C_ARB_TIMEOUT_EN
    // Owner stalls after WR: after 15 stalled cycles a STOP is injected and source 1 takes over.
    do_reset();
    send(0, 8'h00); send(0, 8'h80);
    load(1, 8'h00); load(1, 8'h20);
    sb_push(0, 8'h20);
    sb_push(1, 8'h00); sb_push(1, 8'h20);
    drive();
    for (int k = 1; k <= 18; k++) begin
      step();
      check("tmo_err_quiet", err_o, 1'b0);
    end
    abort_win = 1'b1;
    step();
    abort_win = 1'b0;
    check("tmo_err_pulse", err_o, 1'b1);
    step();
    check("tmo_err_single", err_o, 1'b0);
    check("tmo_next_grant", grant_o, 2'b10);
    run_until_idle("tmo_idle", 10);
`endif

    check("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
